// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register ID-stage stall scoreboard for fixed- and variable-latency producers
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_reg_write,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                id_var_lat,
  input  logic                flush,
  input  logic                wb_done,
  input  logic [REG_W-1:0]    wb_rd,
  output logic                stalln,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    stall_count
);
  logic [LAT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] r_var;
  logic [CNT_W-1:0]    r_stall;
  logic [NUM_REGS-1:0] w_busy, w_wb, w_pend;
  logic                w_raw, w_waw, w_issue;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
    assign w_busy[g] = (g != 0) && ((r_cnt[g] != '0) || r_var[g]);
  end
  // A same-cycle writeback releases its register before the hazard check.
  assign w_wb    = wb_done ? (NUM_REGS'(1) << wb_rd) : '0;
  assign w_pend  = w_busy & ~w_wb;
  assign w_raw   = (id_uses_rs1 && w_pend[id_rs1]) || (id_uses_rs2 && w_pend[id_rs2]);
  assign w_waw   = id_reg_write && (id_rd != '0) && r_var[id_rd] && !w_wb[id_rd];
  assign stalln  = !(id_valid && !flush && (w_raw || w_waw));
  assign w_issue = id_valid && stalln && !flush && id_reg_write && (id_rd != '0);
  assign pending_mask = w_busy;
  assign stall_count  = r_stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_var   <= '0;
      r_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_issue && id_rd == REG_W'(i)) begin
          r_cnt[i] <= id_var_lat ? '0 : id_lat;
          r_var[i] <= id_var_lat;
        end else begin
          r_cnt[i] <= (r_cnt[i] != '0) ? r_cnt[i] - 1'b1 : r_cnt[i];
          r_var[i] <= r_var[i] && !w_wb[i];
        end
      end
      if (!stalln && !(&r_stall)) r_stall <= r_stall + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks of hazard_scoreboard against a behavioural model
module tb_hazard_scoreboard;
  localparam int NR = 32, RW = 5, LW = 3, CW = 8;
  localparam int SC_MAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_var_lat, flush, wb_done;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [LW-1:0] id_lat;
  logic stalln;
  logic [NR-1:0] pending_mask;
  logic [CW-1:0] stall_count;
  int vecs = 0, errs = 0;
  int m_cnt [NR];
  bit m_var [NR];
  int m_sc = 0;

  hazard_scoreboard #(.NUM_REGS(NR), .REG_W(RW), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .id_var_lat(id_var_lat), .flush(flush),
    .wb_done(wb_done), .wb_rd(wb_rd), .stalln(stalln), .pending_mask(pending_mask),
    .stall_count(stall_count));

  always #5 clk = ~clk;

  function automatic bit wb_hits(int r);
    return wb_done && int'(wb_rd) == r;
  endfunction

  function automatic bit pend(int r);
    return r != 0 && (m_cnt[r] > 0 || m_var[r]) && !wb_hits(r);
  endfunction

  function automatic bit exp_stall();
    bit raw, waw;
    raw = (id_uses_rs1 && pend(int'(id_rs1))) || (id_uses_rs2 && pend(int'(id_rs2)));
    waw = id_reg_write && id_rd != 0 && m_var[int'(id_rd)] && !wb_hits(int'(id_rd));
    return id_valid && !flush && (raw || waw);
  endfunction

  function automatic logic [NR-1:0] exp_mask();
    logic [NR-1:0] m = '0;
    for (int r = 1; r < NR; r++) m[r] = (m_cnt[r] > 0) || m_var[r];
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_cnt[r] = 0;
        m_var[r] = 0;
      end
      m_sc = 0;
    end else begin
      bit st, iss;
      st  = exp_stall();
      iss = id_valid && !st && !flush && id_reg_write && id_rd != 0;
      for (int r = 0; r < NR; r++) begin
        if (m_cnt[r] > 0) m_cnt[r]--;
        if (wb_hits(r)) m_var[r] = 0;
      end
      if (iss) begin
        m_cnt[int'(id_rd)] = id_var_lat ? 0 : int'(id_lat);
        m_var[int'(id_rd)] = id_var_lat;
      end
      if (st && m_sc < SC_MAX) m_sc++;
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_stalln", 32'(stalln), 32'(!exp_stall()));
      chk("model_mask", 32'(pending_mask), 32'(exp_mask()));
      chk("model_count", 32'(stall_count), 32'(m_sc));
    end
  end

  task automatic set(bit v, int r1, int r2, bit u1, bit u2, int rd, bit rw, int lat, bit vl,
                     bit fl, bit wd, int wr);
    id_valid = v; id_rs1 = RW'(r1); id_rs2 = RW'(r2); id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = RW'(rd); id_reg_write = rw; id_lat = LW'(lat); id_var_lat = vl; flush = fl;
    wb_done = wd; wb_rd = RW'(wr);
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic prod(int rd, int lat, bit vl);
    set(1, 0, 0, 0, 0, rd, 1, lat, vl, 0, 0, 0);
  endtask

  task automatic cons(int r1, int r2, bit u1, bit u2);
    set(1, r1, r2, u1, u2, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stalln", 32'(stalln), 1);
    chk("rst_mask", 32'(pending_mask), 0);
    chk("rst_count", 32'(stall_count), 0);
    nxt(); prod(5, 1, 0);
    @(negedge clk); chk("load_issue_stalln", 32'(stalln), 1);
    nxt(); set(1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("loaduse_stall", 32'(stalln), 0);
    chk("loaduse_mask5", 32'(pending_mask[5]), 1);
    @(negedge clk);
    chk("loaduse_release", 32'(stalln), 1);
    chk("loaduse_count", 32'(stall_count), 1);
    nxt(); prod(7, 3, 0);
    nxt(); cons(7, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mul_stall", 32'(stalln), 0);
      chk("mul_mask7", 32'(pending_mask[7]), 1);
    end
    @(negedge clk);
    chk("mul_release", 32'(stalln), 1);
    chk("mul_mask7_clear", 32'(pending_mask[7]), 0);
    chk("mul_count", 32'(stall_count), 4);
    nxt(); prod(8, 0, 1);
    nxt(); cons(8, 0, 1, 0);
    repeat (9) begin
      @(negedge clk); chk("div_wait", 32'(stalln), 0);
    end
    nxt(); set(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8);
    @(negedge clk);
    chk("div_wb_bypass", 32'(stalln), 1);
    chk("div_mask_registered", 32'(pending_mask[8]), 1);
    chk("div_count", 32'(stall_count), 13);
    nxt(); idle();
    @(negedge clk); chk("div_var_cleared", 32'(pending_mask[8]), 0);
    nxt(); prod(0, 1, 0);
    nxt(); cons(0, 0, 1, 1);
    @(negedge clk); chk("x0_never_pending", 32'(stalln), 1);
    nxt(); prod(9, 2, 0);
    nxt(); cons(0, 9, 1, 0);
    @(negedge clk);
    chk("rs2_unused", 32'(stalln), 1);
    chk("rs2_mask9", 32'(pending_mask[9]), 1);
    nxt(); idle();
    nxt(); prod(8, 0, 1);
    nxt(); set(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("waw_stall", 32'(stalln), 0);
    nxt(); set(1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0);
    @(negedge clk); chk("waw_flush_stalln", 32'(stalln), 1);
    nxt(); idle();
    repeat (3) begin
      @(negedge clk); chk("flush_no_issue", 32'(pending_mask[8]), 1);
    end
    nxt(); set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    nxt(); idle();
    @(negedge clk); chk("waw_wb_clear", 32'(pending_mask[8]), 0);
    nxt(); prod(5, 3, 0);
    nxt(); cons(5, 0, 1, 0);
    @(negedge clk); chk("mid_stall", 32'(stalln), 0);
    #2 rst = 1;
    #1;
    chk("async_rst_mask", 32'(pending_mask), 0);
    chk("async_rst_count", 32'(stall_count), 0);
    chk("async_rst_stalln", 32'(stalln), 1);
    nxt(); rst = 0;
    repeat (3000) begin
      nxt();
      set($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7));
    end
    nxt(); idle();
    @(negedge clk);
    chk("count_saturated", 32'(stall_count), SC_MAX);
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
